// File: rtl/zbuf_pkg.sv
// ---------------------------------------------------------------------------
// zbuf_pkg
// Shared constants, widths, FSM state type and the address helper for the
// tiled z-buffer. The address generator and the tile reader both use it.
// The z-buffer is 20x15 tiles of 32x32 16-bit depth words.
// ---------------------------------------------------------------------------
package zbuf_pkg;

    localparam int TILE_SHIFT      = 5;
    localparam int TILE_WORDS      = 1024;
    localparam int BLK_BYTES_SHIFT = 11;

    localparam int FB_W = 640;
    localparam int FB_H = 480;

    localparam logic [15:0] ZBUF_CLEAR_VAL = 16'hFFFF;

    localparam int BLK_W  = 9;
    localparam int IDX_W  = 10;
    localparam int FRAG_W = 19;
    localparam int BX_W   = 5;
    localparam int BY_W   = 4;
    localparam int PIX_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_CLR  = 3'd4,
        ST_DONE = 3'd5
    } zbuf_state_t;

    // Byte address of one depth word. A tile is 1024 words (2 KiB), and each
    // word is 2 bytes. The add wraps at 32 bits.
    function automatic logic [31:0] zbuf_addr(input logic [31:0]      base,
                                              input logic [BLK_W-1:0] blk,
                                              input logic [IDX_W-1:0] idx);
        return base + {12'd0, blk, 11'd0} + {21'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/zbuf_tile_counter.sv
// ---------------------------------------------------------------------------
// zbuf_tile_counter
// This is the nested scan counter for the tiled z-buffer. The order is idx
// (word within a tile), then bx (tile column), then by (tile row). It also
// computes the linear tile number and flags the last word of the frame.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   clear        reset the counters to the frame origin (has priority)
//   advance      step to the next word in row-major tile order
//   idx          word index within the tile, iy*32 + ix
//   bx, by       tile column / tile row
//   blk          by*BLK_X + bx
//   last         the counters point at the final word of the frame
// ---------------------------------------------------------------------------
module zbuf_tile_counter
    import zbuf_pkg::*;
#(
    parameter int BLK_X = 20,
    parameter int BLK_Y = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic [BX_W-1:0]  bx,
    output logic [BY_W-1:0]  by,
    output logic [BLK_W-1:0] blk,
    output logic             last
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BX_W-1:0]  bx_q,  bx_d;
    logic [BY_W-1:0]  by_q,  by_d;

    logic idx_wrap;
    logic bx_wrap;
    logic by_wrap;

    assign idx_wrap = (idx_q == IDX_W'(TILE_WORDS - 1));
    assign bx_wrap  = (bx_q  == BX_W'(BLK_X - 1));
    assign by_wrap  = (by_q  == BY_W'(BLK_Y - 1));

    always_comb begin
        idx_d = idx_q;
        bx_d  = bx_q;
        by_d  = by_q;
        if (clear) begin
            idx_d = '0;
            bx_d  = '0;
            by_d  = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
            if (idx_wrap) begin
                if (bx_wrap) begin
                    bx_d = '0;
                    by_d = by_wrap ? '0 : by_q + 1'b1;
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            bx_q  <= '0;
            by_q  <= '0;
        end else begin
            idx_q <= idx_d;
            bx_q  <= bx_d;
            by_q  <= by_d;
        end
    end

    assign idx  = idx_q;
    assign bx   = bx_q;
    assign by   = by_q;
    assign blk  = BLK_W'(by_q) * BLK_W'(BLK_X) + BLK_W'(bx_q);
    assign last = idx_wrap & bx_wrap & by_wrap;

endmodule

// File: rtl/zbuf_tile_reader.sv
// ---------------------------------------------------------------------------
// zbuf_tile_reader
// This block reads back the tiled z-buffer. When a frame starts it walks every
// tile in row-major tile order and issues one 16-bit read per pixel. Each
// word is returned downstream with its pixel coordinates and fragment ID.
//
// Optional feature macro: ZBUF_READ_CLEAR_EN
//   When defined, every read is followed by a write of ZBUF_CLEAR_VAL
//   (far plane) to the same address. The extra outputs are mem_we and
//   mem_wdata. frame_done waits until the last clear is acknowledged.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   nd / us_rfd         frame start request / idle and ready for a frame
//   mem_req, mem_addr   memory request (held until mem_ack), byte address
//   mem_ack             request accepted this cycle
//   mem_rvld, mem_rdata read data strobe and depth word
//   mem_we, mem_wdata   clear write (ZBUF_READ_CLEAR_EN only)
//   ds_rfd / rdy        downstream ready / output valid
//   pix_x, pix_y        pixel coordinates
//   depth, frag_id      depth word, {blk, idx}
//   frame_done          one-cycle pulse at end of frame
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for nd, us_rfd=1
// REQ   | read request outstanding, mem_req=1
// WAIT  | read accepted, waiting for mem_rvld
// EMIT  | pixel presented (rdy=1) until ds_rfd
// CLR   | far-plane write outstanding (ZBUF_READ_CLEAR_EN only)
// DONE  | frame_done pulse
// ---------------------------------------------------------------------------
module zbuf_tile_reader
    import zbuf_pkg::*;
#(
    parameter logic [31:0] ZBUF_LOW_ADDR = 32'h0000_0000,
    parameter int          BLK_X         = 20,
    parameter int          BLK_Y         = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nd,
    output logic              us_rfd,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvld,
    input  logic [15:0]       mem_rdata,
`ifdef ZBUF_READ_CLEAR_EN
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
`endif
    input  logic              ds_rfd,
    output logic              rdy,
    output logic [PIX_W-1:0]  pix_x,
    output logic [PIX_W-1:0]  pix_y,
    output logic [15:0]       depth,
    output logic [FRAG_W-1:0] frag_id,
    output logic              frame_done
);

    zbuf_state_t state_q, state_d;

    logic              us_rfd_q,     us_rfd_d;
    logic              mem_req_q,    mem_req_d;
    logic              rdy_q,        rdy_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       depth_q,      depth_d;
    logic [PIX_W-1:0]  pix_x_q,      pix_x_d;
    logic [PIX_W-1:0]  pix_y_q,      pix_y_d;
    logic [FRAG_W-1:0] frag_id_q,    frag_id_d;
`ifdef ZBUF_READ_CLEAR_EN
    logic              mem_we_q,     mem_we_d;
`endif

    logic             cnt_clear;
    logic             cnt_advance;
    logic             capture;
    logic [IDX_W-1:0] cnt_idx;
    logic [BX_W-1:0]  cnt_bx;
    logic [BY_W-1:0]  cnt_by;
    logic [BLK_W-1:0] cnt_blk;
    logic             cnt_last;

    zbuf_tile_counter #(
        .BLK_X (BLK_X),
        .BLK_Y (BLK_Y)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .idx     (cnt_idx),
        .bx      (cnt_bx),
        .by      (cnt_by),
        .blk     (cnt_blk),
        .last    (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (nd) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (mem_rvld) begin
                        capture = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvld) begin
                    capture = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (ds_rfd) begin
`ifdef ZBUF_READ_CLEAR_EN
                    // The counters hold until the clear write goes out, so
                    // the clear hits the word that was just read.
                    state_d = ST_CLR;
`else
                    cnt_advance = 1'b1;
                    state_d     = cnt_last ? ST_DONE : ST_REQ;
`endif
                end
            end
`ifdef ZBUF_READ_CLEAR_EN
            ST_CLR: begin
                if (mem_ack) begin
                    cnt_advance = 1'b1;
                    state_d     = cnt_last ? ST_DONE : ST_REQ;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The handshake outputs are registered decodes of the next state.
        us_rfd_d     = (state_d == ST_IDLE);
        mem_req_d    = (state_d == ST_REQ) || (state_d == ST_CLR);
        rdy_d        = (state_d == ST_EMIT);
        frame_done_d = (state_d == ST_DONE);
`ifdef ZBUF_READ_CLEAR_EN
        mem_we_d     = (state_d == ST_CLR);
`endif

        depth_d   = depth_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        frag_id_d = frag_id_q;
        if (capture) begin
            depth_d   = mem_rdata;
            pix_x_d   = {cnt_bx, cnt_idx[TILE_SHIFT-1:0]};
            pix_y_d   = PIX_W'({cnt_by, cnt_idx[IDX_W-1:TILE_SHIFT]});
            frag_id_d = {cnt_blk, cnt_idx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            us_rfd_q     <= 1'b1;
            mem_req_q    <= 1'b0;
            rdy_q        <= 1'b0;
            frame_done_q <= 1'b0;
            depth_q      <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frag_id_q    <= '0;
`ifdef ZBUF_READ_CLEAR_EN
            mem_we_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            us_rfd_q     <= us_rfd_d;
            mem_req_q    <= mem_req_d;
            rdy_q        <= rdy_d;
            frame_done_q <= frame_done_d;
            depth_q      <= depth_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frag_id_q    <= frag_id_d;
`ifdef ZBUF_READ_CLEAR_EN
            mem_we_q     <= mem_we_d;
`endif
        end
    end

    // The address is built from the counter flops. They only move when a
    // pixel finishes, so the address stays stable for the whole request.
    assign mem_addr   = zbuf_addr(ZBUF_LOW_ADDR, cnt_blk, cnt_idx);

    assign us_rfd     = us_rfd_q;
    assign mem_req    = mem_req_q;
    assign rdy        = rdy_q;
    assign frame_done = frame_done_q;
    assign depth      = depth_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frag_id    = frag_id_q;
`ifdef ZBUF_READ_CLEAR_EN
    assign mem_we     = mem_we_q;
    assign mem_wdata  = ZBUF_CLEAR_VAL;
`endif

endmodule

// File: tb/tb_zbuf_tile_reader.sv
// ---------------------------------------------------------------------------
// tb_zbuf_tile_reader
// Directed bench for zbuf_tile_reader. It uses a 3x2 tile grid, so one frame
// is 6144 pixels. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_zbuf_tile_reader;

    logic        clk;
    logic        rst_n;
    logic        nd;
    logic        us_rfd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvld;
    logic [15:0] mem_rdata;
`ifdef ZBUF_READ_CLEAR_EN
    logic        mem_we;
    logic [15:0] mem_wdata;
`endif
    logic        ds_rfd;
    logic        rdy;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] depth;
    logic [18:0] frag_id;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;
    int hs_cnt  = 0;
    int fd_cnt  = 0;

    zbuf_tile_reader #(
        .ZBUF_LOW_ADDR (32'h0000_0000),
        .BLK_X         (3),
        .BLK_Y         (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nd         (nd),
        .us_rfd     (us_rfd),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvld   (mem_rvld),
        .mem_rdata  (mem_rdata),
`ifdef ZBUF_READ_CLEAR_EN
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
`endif
        .ds_rfd     (ds_rfd),
        .rdy        (rdy),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .depth      (depth),
        .frag_id    (frag_id),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdy && ds_rfd) hs_cnt <= hs_cnt + 1;
        if (frame_done)    fd_cnt <= fd_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int t;
        t = 0;
        while (mem_req !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic model(input int n, output logic [31:0] a, output logic [9:0] x,
                         output logic [9:0] y, output logic [18:0] f);
        int blk;
        int idx;
        blk = n / 1024;
        idx = n % 1024;
        a = 32'(blk * 2048 + idx * 2);
        x = 10'((blk % 3) * 32 + idx % 32);
        y = 10'((blk / 3) * 32 + idx / 32);
        f = 19'(blk * 1024 + idx);
    endtask

    // Serve one pixel. The ack is delayed ack_wait cycles, and the data
    // comes rvld_wait cycles after the ack (0 means the same cycle as the
    // ack). The pixel is then held for hold cycles and accepted.
    task automatic serve(input string tag, input logic [31:0] e_addr, input logic [9:0] e_x,
                         input logic [9:0] e_y, input logic [18:0] e_frag, input logic [15:0] data,
                         input int ack_wait, input int rvld_wait, input int hold);
        wait_req(tag);
        chk({tag, "_addr"}, mem_addr, e_addr);
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            chk({tag, "_req_hold"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_addr_hold"}, mem_addr, e_addr);
        end
        mem_ack   = 1'b1;
        mem_rvld  = (rvld_wait == 0);
        mem_rdata = data;
        tick();
        mem_ack  = 1'b0;
        mem_rvld = 1'b0;
        if (rvld_wait > 0) begin
            chk({tag, "_wait_req"}, {31'd0, mem_req}, 32'd0);
            for (int i = 1; i < rvld_wait; i++) tick();
            mem_rvld  = 1'b1;
            mem_rdata = data;
            tick();
            mem_rvld = 1'b0;
        end
        chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
        chk({tag, "_depth"}, {16'd0, depth}, {16'd0, data});
        chk({tag, "_x"}, {22'd0, pix_x}, {22'd0, e_x});
        chk({tag, "_y"}, {22'd0, pix_y}, {22'd0, e_y});
        chk({tag, "_frag"}, {13'd0, frag_id}, {13'd0, e_frag});
        for (int i = 0; i < hold; i++) begin
            nd        = 1'b1;
            mem_rvld  = 1'b1;
            mem_rdata = ~data;
            tick();
            chk({tag, "_hold_rdy"}, {31'd0, rdy}, 32'd1);
            chk({tag, "_hold_depth"}, {16'd0, depth}, {16'd0, data});
            chk({tag, "_hold_x"}, {22'd0, pix_x}, {22'd0, e_x});
            chk({tag, "_hold_y"}, {22'd0, pix_y}, {22'd0, e_y});
            chk({tag, "_hold_frag"}, {13'd0, frag_id}, {13'd0, e_frag});
            chk({tag, "_hold_noreq"}, {31'd0, mem_req}, 32'd0);
        end
        nd       = 1'b0;
        mem_rvld = 1'b0;
        ds_rfd   = 1'b1;
        tick();
        ds_rfd = 1'b0;
        chk({tag, "_rdy_drop"}, {31'd0, rdy}, 32'd0);
`ifdef ZBUF_READ_CLEAR_EN
        wait_req({tag, "_clr"});
        chk({tag, "_clr_we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_clr_addr"}, mem_addr, e_addr);
        chk({tag, "_clr_wdata"}, {16'd0, mem_wdata}, 32'h0000_FFFF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_clr_we_drop"}, {31'd0, mem_we}, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [18:0] f;
        logic [15:0] d;
        int          hs0;
        int          fd0;

        rst_n     = 1'b0;
        nd        = 1'b0;
        mem_ack   = 1'b0;
        mem_rvld  = 1'b0;
        mem_rdata = 16'h0;
        ds_rfd    = 1'b0;
        tick();
        tick();
        chk("rst_us_rfd", {31'd0, us_rfd}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_frag", {13'd0, frag_id}, 32'd0);
        rst_n = 1'b1;
        ds_rfd = 1'b1;
        tick();
        ds_rfd = 1'b0;
        chk("idle_ds_rfd_rdy", {31'd0, rdy}, 32'd0);
        chk("idle_ds_rfd_req", {31'd0, mem_req}, 32'd0);

        // Full frame
        hs0 = hs_cnt;
        fd0 = fd_cnt;
        nd = 1'b1;
        tick();
        nd = 1'b0;
        chk("start_us_rfd", {31'd0, us_rfd}, 32'd0);
        chk("start_req", {31'd0, mem_req}, 32'd1);
        for (int n = 0; n < 6144; n++) begin
            d = 16'(n * 7) ^ 16'h5A5A;
            case (n)
                0:       serve("p0",    32'h0000_0000, 10'd0,  10'd0,  19'h00000, d, 1, 1, 0);
                1:       serve("p1",    32'h0000_0002, 10'd1,  10'd0,  19'h00001, d, 1, 1, 0);
                32:      serve("p32",   32'h0000_0040, 10'd0,  10'd1,  19'h00020, d, 0, 0, 0);
                1024:    serve("b1",    32'h0000_0800, 10'd32, 10'd0,  19'h00400, d, 0, 0, 5);
                1025:    serve("ack4",  32'h0000_0802, 10'd33, 10'd0,  19'h00401, 16'h1234, 4, 0, 0);
                3072:    serve("b3",    32'h0000_1800, 10'd0,  10'd32, 19'h00C00, d, 0, 0, 0);
                6143:    serve("last",  32'h0000_2FFE, 10'd95, 10'd63, 19'h017FF, d, 0, 2, 0);
                default: begin
                    model(n, a, x, y, f);
                    serve("px", a, x, y, f, d, 0, 0, 0);
                end
            endcase
        end
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_us_rfd", {31'd0, us_rfd}, 32'd0);
        tick();
        chk("done_drop", {31'd0, frame_done}, 32'd0);
        chk("idle_us_rfd", {31'd0, us_rfd}, 32'd1);
        chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("handshakes", hs_cnt - hs0, 32'd6144);
        chk("frame_done_count", fd_cnt - fd0, 32'd1);

        // Reset during WAIT, late data, restart
        nd = 1'b1;
        tick();
        nd = 1'b0;
        for (int n = 0; n < 3; n++) begin
            model(n, a, x, y, f);
            serve("r", a, x, y, f, 16'(16'hC000 + n), 0, 0, 0);
        end
        wait_req("r3");
        chk("r3_addr", mem_addr, 32'h0000_0006);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("r3_wait_req", {31'd0, mem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_rdy", {31'd0, rdy}, 32'd0);
        chk("arst_us_rfd", {31'd0, us_rfd}, 32'd1);
        chk("arst_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_rvld  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_rvld = 1'b0;
        chk("late_rvld_rdy", {31'd0, rdy}, 32'd0);
        chk("late_rvld_us_rfd", {31'd0, us_rfd}, 32'd1);
        chk("late_rvld_depth", {16'd0, depth}, 32'd0);
        nd = 1'b1;
        tick();
        nd = 1'b0;
        serve("restart", 32'h0000_0000, 10'd0, 10'd0, 19'h00000, 16'h7777, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
